// File: rtl/avalon_ram_pkg.sv
// Shared definitions for the Avalon-MM RAM model.
//   state_e            : transfer FSM states
//   DEFAULT_BASE_ADDR  : byte address of word 0 when the instantiation does not override it
//   DATA_W_MIN/MAX     : legal data bus width range (bits, multiple of 8)
//   WAIT_LIMIT         : largest wait-state count the counter can hold
//   WAIT_CNT_W         : wait counter width
//   data_w_ok/is_pow2  : parameter sanity helpers
package avalon_ram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_e;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'hBFC0_0000;

  localparam int DATA_W_MIN = 8;
  localparam int DATA_W_MAX = 128;
  localparam int WAIT_LIMIT = 15;
  localparam int WAIT_CNT_W = 4;

  function automatic bit data_w_ok(input int w);
    return (w >= DATA_W_MIN) && (w <= DATA_W_MAX) && ((w % 8) == 0);
  endfunction

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/avalon_ram_model_if.sv
// Avalon-MM slave bus bundle for the RAM model.
//   master modport : drives address/byteenable/read/write/writedata, sees waitrequest/readdata
//   slave modport  : the RAM side of the same signals
interface avalon_ram_model_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);

  logic [ADDR_W-1:0]   address;
  logic [DATA_W/8-1:0] byteenable;
  logic                read;
  logic                write;
  logic [DATA_W-1:0]   writedata;
  logic                waitrequest;
  logic [DATA_W-1:0]   readdata;

  modport master (
    output address, byteenable, read, write, writedata,
    input  waitrequest, readdata
  );

  modport slave (
    input  address, byteenable, read, write, writedata,
    output waitrequest, readdata
  );

endinterface

// File: rtl/avalon_wait_gen.sv
// Wait-state count source for the RAM model.
// Macro AVALON_RAM_RANDOM_WAIT_EN: when defined, each accepted transfer
// draws a fresh count in 0..MAX_WAIT for the next transfer; when undefined
// the count is always WAIT_CYCLES.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   take       : pulses when the FSM consumes wait_n for a new transfer
//   wait_n     : wait-state count for the transfer being accepted
module avalon_wait_gen
  import avalon_ram_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int MAX_WAIT    = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  take,
  output logic [WAIT_CNT_W-1:0] wait_n
);

`ifdef AVALON_RAM_RANDOM_WAIT_EN
  logic unused_ok;
  assign unused_ok = &{1'b0, (WAIT_CYCLES > 0)};

  // The count is pre-drawn so it is stable while the FSM samples it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_n <= '0;
    end else if (take) begin
      wait_n <= WAIT_CNT_W'($urandom_range(0, MAX_WAIT));
    end
  end
`else
  logic unused_ok;
  assign unused_ok = &{1'b0, clk, rst_n, take, (MAX_WAIT > 0)};

  assign wait_n = WAIT_CNT_W'(WAIT_CYCLES);
`endif

endmodule

// File: rtl/avalon_ram_model.sv
// Avalon-MM slave RAM model with programmable wait states.
// Optional macro AVALON_RAM_RANDOM_WAIT_EN (see avalon_wait_gen) randomises
// the per-transfer wait count.
// Ports:
//   clk, rst_n   : clock (rising edge), async active-low reset
//   bus          : Avalon-MM slave (address, byteenable, read, write,
//                  writedata, waitrequest, registered readdata)
//   oob          : one-cycle pulse in ACK when the access fell outside the window
//   protocol_err : sticky, set when read and write are asserted together
//
// state   | meaning
// ST_IDLE | no transfer in progress, waiting for a single request
// ST_WAIT | counting down wait states for the accepted request
// ST_ACK  | access done on entry, waitrequest low for one cycle
module avalon_ram_model
  import avalon_ram_pkg::*;
#(
  parameter int                DATA_W      = 32,
  parameter int                ADDR_W      = 32,
  parameter int                DEPTH       = 4096,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = ADDR_W'(DEFAULT_BASE_ADDR),
  parameter int                WAIT_CYCLES = 2,
  parameter int                MAX_WAIT    = 5,
  parameter string             INIT_FILE   = ""
) (
  input  logic              clk,
  input  logic              rst_n,
  avalon_ram_model_if.slave bus,
  output logic              oob,
  output logic              protocol_err
);

  localparam int BYTES     = DATA_W / 8;
  localparam int LANE_BITS = $clog2(BYTES);
  localparam int IDX_W     = $clog2(DEPTH);
  localparam logic [ADDR_W:0] WINDOW = (ADDR_W + 1)'(DEPTH * BYTES);

  logic [DATA_W-1:0] mem [DEPTH];

  state_e                state, state_nxt;
  logic [WAIT_CNT_W-1:0] cnt, cnt_nxt, wait_n;
  logic                  take_n, access, perr_set, ready;
  logic                  req_rd, req_wr, req_any, req_both;
  logic [ADDR_W-1:0]     offset;
  logic [IDX_W-1:0]      word_idx;
  logic                  in_window;
  logic [DATA_W-1:0]     readdata_q;

  assign req_rd   = bus.read;
  assign req_wr   = bus.write;
  assign req_any  = req_rd | req_wr;
  assign req_both = req_rd & req_wr;

  // Unsigned subtraction makes addresses below the base wrap to large
  // offsets, so a single compare catches both sides of the window.
  assign offset    = bus.address - BASE_ADDR;
  assign word_idx  = IDX_W'(offset >> LANE_BITS);
  assign in_window = {1'b0, offset} < WINDOW;

  avalon_wait_gen #(
    .WAIT_CYCLES (WAIT_CYCLES),
    .MAX_WAIT    (MAX_WAIT)
  ) u_wait_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .take   (take_n),
    .wait_n (wait_n)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    take_n    = 1'b0;
    access    = 1'b0;
    perr_set  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_both) begin
          perr_set = 1'b1;
        end else if (req_any && ready) begin
          take_n = 1'b1;
          if (wait_n == '0) begin
            state_nxt = ST_ACK;
            access    = 1'b1;
          end else begin
            state_nxt = ST_WAIT;
            cnt_nxt   = wait_n;
          end
        end
      end
      ST_WAIT: begin
        if (req_both) begin
          perr_set  = 1'b1;
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else if (!req_any) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else if (cnt <= WAIT_CNT_W'(1)) begin
          state_nxt = ST_ACK;
          cnt_nxt   = '0;
          access    = 1'b1;
        end else begin
          cnt_nxt = cnt - WAIT_CNT_W'(1);
        end
      end
      ST_ACK: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // ready stays low while reset is held, so no access (and no memory write)
  // can be decoded from a request that is present during reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      ready        <= 1'b0;
      readdata_q   <= '0;
      oob          <= 1'b0;
      protocol_err <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      ready <= 1'b1;
      oob   <= access & ~in_window;
      if (perr_set) begin
        protocol_err <= 1'b1;
      end
      if (access && req_rd) begin
        readdata_q <= mem[word_idx];
      end
    end
  end

  // Memory contents survive reset.
  always_ff @(posedge clk) begin
    if (access && req_wr) begin
      for (int k = 0; k < BYTES; k++) begin
        if (bus.byteenable[k]) begin
          mem[word_idx][k*8 +: 8] <= bus.writedata[k*8 +: 8];
        end
      end
    end
  end

  assign bus.waitrequest = req_any && (state != ST_ACK);
  assign bus.readdata    = readdata_q;

endmodule

// File: tb/tb_avalon_ram_model.sv
module tb_avalon_ram_model;

  localparam logic [31:0] BASE  = 32'hBFC0_0000;
  localparam int          DEPTH = 4096;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  avalon_ram_model_if #(.DATA_W(32), .ADDR_W(32)) bus2 ();
  avalon_ram_model_if #(.DATA_W(32), .ADDR_W(32)) bus0 ();
  logic oob2, oob0, perr2, perr0;

  avalon_ram_model #(
    .DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .BASE_ADDR(BASE),
    .WAIT_CYCLES(2), .MAX_WAIT(5), .INIT_FILE("")
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2), .oob(oob2), .protocol_err(perr2)
  );

  avalon_ram_model #(
    .DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .BASE_ADDR(BASE),
    .WAIT_CYCLES(0), .MAX_WAIT(5), .INIT_FILE("")
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0), .oob(oob0), .protocol_err(perr0)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: word array per DUT, which words are known, last read value.
  logic [31:0] mdl_mem   [2][DEPTH];
  bit          mdl_valid [2][DEPTH];
  logic [31:0] mdl_rd    [2];
  bit          mdl_rd_ok [2];

  function automatic int unsigned mdl_index(input logic [31:0] a);
    int unsigned off;
    off = a - BASE;
    return (off / 4) % DEPTH;
  endfunction

  function automatic bit mdl_oob(input logic [31:0] a);
    int unsigned off;
    off = a - BASE;
    return off >= int'(DEPTH * 4);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int k = 0; k < 4; k++) if (be[k]) r[k*8 +: 8] = d[k*8 +: 8];
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int w, input bit rd, input bit wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] be);
    if (w == 0) begin
      bus2.read = rd; bus2.write = wr; bus2.address = a;
      bus2.writedata = d; bus2.byteenable = be;
    end else begin
      bus0.read = rd; bus0.write = wr; bus0.address = a;
      bus0.writedata = d; bus0.byteenable = be;
    end
  endtask

  function automatic logic wreq(input int w);
    return (w == 0) ? bus2.waitrequest : bus0.waitrequest;
  endfunction

  task automatic xfer(input int w, input bit rd, input bit wr, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] be, output int stalls,
                      output logic [31:0] rdata, output logic oob_s);
    @(negedge clk);
    drive(w, rd, wr, a, d, be);
    stalls = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (!wreq(w)) break;
      stalls++;
      @(negedge clk);
    end
    rdata = (w == 0) ? bus2.readdata : bus0.readdata;
    oob_s = (w == 0) ? oob2 : oob0;
    drive(w, 1'b0, 1'b0, a, d, be);
  endtask

  task automatic txn(input string tag, input int w, input bit rd, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] be, input int exp_stalls);
    int          st;
    logic [31:0] rdv;
    logic        oo;
    int unsigned idx;
    idx = mdl_index(a);
    xfer(w, rd, !rd, a, d, be, st, rdv, oo);
    if (rd) begin
      mdl_rd[w]    = mdl_mem[w][idx];
      mdl_rd_ok[w] = mdl_valid[w][idx];
    end else if (mdl_valid[w][idx] || be == 4'hF) begin
      mdl_mem[w][idx]   = merge(mdl_mem[w][idx], d, be);
      mdl_valid[w][idx] = 1'b1;
    end
    check({tag, "_stalls"}, 32'(st), 32'(exp_stalls));
    check({tag, "_oob"}, {31'b0, oo}, {31'b0, mdl_oob(a)});
    if (mdl_rd_ok[w]) check({tag, "_rdata"}, rdv, mdl_rd[w]);
  endtask

  initial begin
    logic [31:0] a, d;
    logic [3:0]  be;
    bit          rd;
    int unsigned idx;

    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, BASE, '0, '0);
    drive(1, 1'b0, 1'b0, BASE, '0, '0);
    for (int w = 0; w < 2; w++) begin
      mdl_rd[w] = '0;
      mdl_rd_ok[w] = 1'b1;
      for (int i = 0; i < DEPTH; i++) mdl_valid[w][i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("rst_rdata", bus2.readdata, 32'h0);
    check("rst_oob", {31'b0, oob2}, 32'h0);
    check("rst_perr", {31'b0, perr2}, 32'h0);
    check("rst_waitreq", {31'b0, bus2.waitrequest}, 32'h0);
    check("rst_rdata0", bus0.readdata, 32'h0);

    // Basic write/read with two wait states.
    txn("wr_deadbeef", 0, 1'b0, 32'hBFC0_0010, 32'hDEAD_BEEF, 4'hF, 3);
    txn("rd_deadbeef", 0, 1'b1, 32'hBFC0_0010, 32'h0, 4'hF, 3);
    check("deadbeef_literal", bus2.readdata, 32'hDEAD_BEEF);

    // Byte-lane merge; the write in between must not disturb readdata.
    txn("wr_preset", 0, 1'b0, 32'hBFC0_0020, 32'h1122_3344, 4'hF, 3);
    txn("wr_lanes", 0, 1'b0, 32'hBFC0_0020, 32'hAABB_CCDD, 4'b0101, 3);
    txn("rd_lanes", 0, 1'b1, 32'hBFC0_0020, 32'h0, 4'hF, 3);
    check("merge_literal", bus2.readdata, 32'h11BB_33DD);

    txn("wr_be0", 0, 1'b0, 32'hBFC0_0020, 32'hFFFF_FFFF, 4'h0, 3);
    txn("rd_be0", 0, 1'b1, 32'hBFC0_0020, 32'h0, 4'hF, 3);
    txn("rd_lowbits", 0, 1'b1, 32'hBFC0_0013, 32'h0, 4'hF, 3);

    // Window wrap above and below.
    txn("wr_word0", 0, 1'b0, 32'hBFC0_0000, $urandom, 4'hF, 3);
    txn("rd_oob_hi", 0, 1'b1, 32'hBFC0_4000, 32'h0, 4'hF, 3);
    @(negedge clk);
    check("oob_pulse_end", {31'b0, oob2}, 32'h0);
    txn("wr_last", 0, 1'b0, 32'hBFC0_3FFC, $urandom, 4'hF, 3);
    txn("rd_oob_lo", 0, 1'b1, 32'hBFBF_FFFC, 32'h0, 4'hF, 3);

    // read+write together in IDLE.
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 32'hBFC0_0020, 32'h0BAD_F00D, 4'hF);
    for (int i = 0; i < 4; i++) begin
      #1;
      check("perr_waitreq", {31'b0, bus2.waitrequest}, 32'h1);
      @(negedge clk);
    end
    check("perr_set", {31'b0, perr2}, 32'h1);
    drive(0, 1'b0, 1'b0, 32'hBFC0_0020, 32'h0, 4'hF);
    txn("rd_after_perr", 0, 1'b1, 32'hBFC0_0020, 32'h0, 4'hF, 3);

    // read+write together while in WAIT.
    @(negedge clk);
    drive(0, 1'b0, 1'b1, 32'hBFC0_0020, 32'h5555_5555, 4'hF);
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 32'hBFC0_0020, 32'h5555_5555, 4'hF);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 32'hBFC0_0020, 32'h0, 4'hF);
    txn("rd_after_perr_wait", 0, 1'b1, 32'hBFC0_0020, 32'h0, 4'hF, 3);
    check("perr_sticky", {31'b0, perr2}, 32'h1);

    // Request dropped in WAIT.
    @(negedge clk);
    drive(0, 1'b0, 1'b1, 32'hBFC0_0010, 32'h0, 4'hF);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 32'hBFC0_0010, 32'h0, 4'hF);
    txn("rd_after_abort", 0, 1'b1, 32'hBFC0_0010, 32'h0, 4'hF, 3);

    // Reset during WAIT of a write.
    @(negedge clk);
    drive(0, 1'b0, 1'b1, 32'hBFC0_0010, 32'h1234_5678, 4'hF);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_rdata", bus2.readdata, 32'h0);
    check("midrst_perr", {31'b0, perr2}, 32'h0);
    check("midrst_oob", {31'b0, oob2}, 32'h0);
    drive(0, 1'b0, 1'b0, 32'hBFC0_0010, 32'h0, 4'hF);
    mdl_rd[0] = '0; mdl_rd_ok[0] = 1'b1;
    mdl_rd[1] = '0; mdl_rd_ok[1] = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    txn("rd_after_rst", 0, 1'b1, 32'hBFC0_0010, 32'h0, 4'hF, 3);

    // Zero wait states.
    txn("w0_wr", 1, 1'b0, 32'hBFC0_0100, $urandom, 4'hF, 1);
    txn("w0_rd", 1, 1'b1, 32'hBFC0_0100, 32'h0, 4'hF, 1);

    // Randomised traffic on both instances.
    for (int n = 0; n < 60; n++) begin
      automatic int w = (n < 40) ? 0 : 1;
      idx = $urandom_range(0, 15) * 97;
      a   = BASE + idx * 4 + $urandom_range(0, 3);
      if ($urandom_range(0, 7) == 0) a = a + 32'h4000 * $urandom_range(1, 3);
      d   = $urandom;
      be  = 4'($urandom_range(0, 15));
      rd  = 1'($urandom_range(0, 1));
      if (!mdl_valid[w][idx]) begin
        rd = 1'b0;
        be = 4'hF;
      end
      txn(rd ? "rnd_rd" : "rnd_wr", w, rd, a, d, be, (w == 0) ? 3 : 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
